// File: rtl/combo_lock_pkg.sv
// Shared state encoding and timer sizing for the combination-lock controller.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_ERR     = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  // Bits needed to hold (longest hold time - 1).
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/combo_lock_if.sv
// Button-pulse / digit inputs and indicator outputs of the lock controller.
interface combo_lock_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
);
  logic [DIGIT_W-1:0]          i_digit;
  logic                        i_enter_pulse;
  logic                        i_clear_pulse;
  logic                        i_set_pulse;
  logic                        o_unlocked;
  logic                        o_prog;
  logic                        o_error;
  logic                        o_locked_out;
  logic [$clog2(CODE_LEN)-1:0] o_entry_count;

  modport master (
    output i_digit, i_enter_pulse, i_clear_pulse, i_set_pulse,
    input  o_unlocked, o_prog, o_error, o_locked_out, o_entry_count
  );

  modport slave (
    input  i_digit, i_enter_pulse, i_clear_pulse, i_set_pulse,
    output o_unlocked, o_prog, o_error, o_locked_out, o_entry_count
  );
endinterface

// File: rtl/lock_timer.sv
// Shared hold-time down-counter: load N-1 on state entry, done while at zero.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst)             r_count <= '0;
    else if (i_load)       r_count <= i_load_val;
    else if (r_count != '0) r_count <= r_count - 1'b1;
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/combo_lock_fsm.sv
// Combination lock: ENTRY collects digits, OPEN unlocked, ERR/LOCKOUT timed
// penalties, PROG captures a new code while unlocked.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int                           DIGIT_W        = 4,
  parameter int                           CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]  CODE           = 16'h1234,
  parameter int                           MAX_FAIL       = 3,
  parameter int                           ERR_CYCLES     = 50_000_000,
  parameter int                           OPEN_CYCLES    = 250_000_000,
  parameter int                           LOCKOUT_CYCLES = 500_000_000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  combo_lock_if.slave    bus
);
  localparam int IW = $clog2(CODE_LEN);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int CW = DIGIT_W * CODE_LEN;
  localparam int TW = timer_w(ERR_CYCLES, OPEN_CYCLES, LOCKOUT_CYCLES);

  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [TW-1:0] ERR_LD   = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);

  state_t            r_state,  w_state_nxt;
  logic [CW-1:0]     r_code,   w_code_nxt;
  logic [CW-1:0]     r_shadow, w_shadow_nxt;
  logic [IW-1:0]     r_idx,    w_idx_nxt;
  logic              r_mis,    w_mis_nxt;
  logic [FW-1:0]     r_fail,   w_fail_nxt;

  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_done;
  logic              w_enter;
  logic              w_set;
  logic              w_mis_all;
  logic [FW-1:0]     w_fail_inc;
  logic [DIGIT_W-1:0] w_cur_digit;
  logic [CW-1:0]     w_shadow_wr;

  // Clear outranks Set, Set outranks Enter; losers are dropped.
  assign w_set   = bus.i_set_pulse & ~bus.i_clear_pulse;
  assign w_enter = bus.i_enter_pulse & ~bus.i_clear_pulse & ~bus.i_set_pulse;

  // Digit 0 sits in the most-significant field.
  always_comb begin
    w_cur_digit = '0;
    w_shadow_wr = r_shadow;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (r_idx == IW'(k)) begin
        w_cur_digit = r_code[(CODE_LEN-1-k)*DIGIT_W +: DIGIT_W];
        w_shadow_wr[(CODE_LEN-1-k)*DIGIT_W +: DIGIT_W] = bus.i_digit;
      end
    end
  end

  assign w_mis_all  = r_mis | (bus.i_digit != w_cur_digit);
  assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_shadow_nxt = r_shadow;
    w_idx_nxt    = r_idx;
    w_mis_nxt    = r_mis;
    w_fail_nxt   = r_fail;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;

    case (r_state)
      ST_ENTRY: begin
        if (bus.i_clear_pulse) begin
          w_idx_nxt = '0;
          w_mis_nxt = 1'b0;
        end else if (w_enter) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            w_mis_nxt = 1'b0;
            if (!w_mis_all) begin
              w_state_nxt = ST_OPEN;
              w_fail_nxt  = '0;
              w_tmr_load  = 1'b1;
              w_tmr_val   = OPEN_LD;
            end else begin
              w_fail_nxt = w_fail_inc;
              w_tmr_load = 1'b1;
              if (w_fail_inc == FAIL_MAX) begin
                w_state_nxt = ST_LOCKOUT;
                w_tmr_val   = LOCK_LD;
              end else begin
                w_state_nxt = ST_ERR;
                w_tmr_val   = ERR_LD;
              end
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_mis_nxt = w_mis_all;
          end
        end
      end

      ST_ERR: begin
        if (w_tmr_done) w_state_nxt = ST_ENTRY;
      end

      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_ENTRY;
          w_fail_nxt  = '0;
        end
      end

      ST_OPEN: begin
        if (bus.i_clear_pulse)  w_state_nxt = ST_ENTRY;
        else if (w_set) begin
          w_state_nxt = ST_PROG;
          w_idx_nxt   = '0;
        end else if (w_tmr_done) w_state_nxt = ST_ENTRY;
      end

      ST_PROG: begin
        if (bus.i_clear_pulse) begin
          w_state_nxt = ST_OPEN;
          w_idx_nxt   = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = OPEN_LD;
        end else if (w_enter) begin
          w_shadow_nxt = w_shadow_wr;
          if (r_idx == LAST_IDX) begin
            w_code_nxt  = w_shadow_wr;
            w_idx_nxt   = '0;
            w_state_nxt = ST_OPEN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = OPEN_LD;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_ENTRY;
      r_code   <= CODE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_mis    <= 1'b0;
      r_fail   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_shadow <= w_shadow_nxt;
      r_idx    <= w_idx_nxt;
      r_mis    <= w_mis_nxt;
      r_fail   <= w_fail_nxt;
    end
  end

  lock_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign bus.o_unlocked    = (r_state == ST_OPEN) || (r_state == ST_PROG);
  assign bus.o_prog        = (r_state == ST_PROG);
  assign bus.o_error       = (r_state == ST_ERR);
  assign bus.o_locked_out  = (r_state == ST_LOCKOUT);
  assign bus.o_entry_count = ((r_state == ST_ENTRY) || (r_state == ST_PROG)) ? r_idx : '0;
endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed + random bench for combo_lock_fsm against a queue-based lock model.
module tb_combo_lock_fsm;
  localparam int DW = 4;
  localparam int CL = 4;
  localparam int MAXF = 3;
  localparam int NERR = 4;
  localparam int NOPEN = 8;
  localparam int NLOCK = 16;

  localparam int M_WAIT = 0;
  localparam int M_OPEN = 1;
  localparam int M_ERR  = 2;
  localparam int M_LOCK = 3;
  localparam int M_PROG = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  combo_lock_if #(.DIGIT_W(DW), .CODE_LEN(CL)) bus ();

  combo_lock_fsm #(
    .DIGIT_W(DW), .CODE_LEN(CL), .CODE(16'h1234), .MAX_FAIL(MAXF),
    .ERR_CYCLES(NERR), .OPEN_CYCLES(NOPEN), .LOCKOUT_CYCLES(NLOCK)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;

  int m_mode;
  int m_code[CL];
  int m_entered[$];
  int m_shadow[$];
  int m_fails;
  int m_rem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_WAIT;
    m_code[0] = 1; m_code[1] = 2; m_code[2] = 3; m_code[3] = 4;
    m_entered.delete();
    m_shadow.delete();
    m_fails = 0;
    m_rem = 0;
  endtask

  task automatic model_step(input bit en, input bit cl, input bit st, input int dg);
    bit ok;
    case (m_mode)
      M_WAIT: begin
        if (cl) m_entered.delete();
        else if (!st && en) begin
          m_entered.push_back(dg);
          if (m_entered.size() == CL) begin
            ok = 1;
            for (int k = 0; k < CL; k++) if (m_entered[k] != m_code[k]) ok = 0;
            m_entered.delete();
            if (ok) begin
              m_mode = M_OPEN; m_rem = NOPEN; m_fails = 0;
            end else begin
              if (m_fails < MAXF) m_fails++;
              if (m_fails == MAXF) begin m_mode = M_LOCK; m_rem = NLOCK; end
              else begin m_mode = M_ERR; m_rem = NERR; end
            end
          end
        end
      end
      M_ERR, M_LOCK: begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_mode == M_LOCK) m_fails = 0;
          m_mode = M_WAIT;
        end
      end
      M_OPEN: begin
        if (cl) m_mode = M_WAIT;
        else if (st) begin m_mode = M_PROG; m_shadow.delete(); end
        else begin
          m_rem--;
          if (m_rem == 0) m_mode = M_WAIT;
        end
      end
      M_PROG: begin
        if (cl) begin
          m_shadow.delete(); m_mode = M_OPEN; m_rem = NOPEN;
        end else if (!st && en) begin
          m_shadow.push_back(dg);
          if (m_shadow.size() == CL) begin
            for (int k = 0; k < CL; k++) m_code[k] = m_shadow[k];
            m_shadow.delete(); m_mode = M_OPEN; m_rem = NOPEN;
          end
        end
      end
      default: m_mode = M_WAIT;
    endcase
  endtask

  task automatic check_all();
    int cnt;
    cnt = (m_mode == M_WAIT) ? m_entered.size() : (m_mode == M_PROG) ? m_shadow.size() : 0;
    check("unlocked", 32'(bus.o_unlocked), 32'((m_mode == M_OPEN) || (m_mode == M_PROG)));
    check("prog", 32'(bus.o_prog), 32'(m_mode == M_PROG));
    check("error", 32'(bus.o_error), 32'(m_mode == M_ERR));
    check("locked_out", 32'(bus.o_locked_out), 32'(m_mode == M_LOCK));
    check("entry_count", 32'(bus.o_entry_count), 32'(cnt));
  endtask

  task automatic tick(input bit en, input bit cl, input bit st, input int dg, input bit rs = 1'b0);
    bus.i_enter_pulse = en;
    bus.i_clear_pulse = cl;
    bus.i_set_pulse   = st;
    bus.i_digit       = DW'(dg);
    i_rst             = rs;
    @(posedge i_clk);
    if (rs) model_reset();
    else model_step(en, cl, st, dg);
    #1;
    check_all();
    bus.i_enter_pulse = 1'b0;
    bus.i_clear_pulse = 1'b0;
    bus.i_set_pulse   = 1'b0;
    i_rst             = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    tick(1, 0, 0, a); tick(1, 0, 0, b); tick(1, 0, 0, c); tick(1, 0, 0, d);
  endtask

  initial begin
    int r;
    int dg;
    bus.i_enter_pulse = 1'b0;
    bus.i_clear_pulse = 1'b0;
    bus.i_set_pulse   = 1'b0;
    bus.i_digit       = '0;
    model_reset();

    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    idle(2);

    // correct code, full OPEN hold
    enter4(1, 2, 3, 4);
    check("open_after_4th", 32'(bus.o_unlocked), 32'd1);
    idle(10);
    check("open_expired", 32'(bus.o_unlocked), 32'd0);

    // one wrong, then right
    enter4(1, 2, 9, 4);
    check("err_after_wrong", 32'(bus.o_error), 32'd1);
    idle(5);
    enter4(1, 2, 3, 4);
    idle(10);

    // three wrong -> lockout, presses ignored during it
    enter4(5, 5, 5, 5); idle(5);
    enter4(1, 2, 3, 5); idle(5);
    enter4(0, 0, 0, 0);
    check("lockout_entered", 32'(bus.o_locked_out), 32'd1);
    tick(1, 0, 0, 1); tick(1, 0, 0, 2); tick(1, 1, 1, 3); tick(1, 0, 0, 4);
    idle(14);
    enter4(1, 2, 3, 4);
    idle(10);

    // clear mid-entry, clear+enter same cycle
    tick(1, 0, 0, 1); tick(1, 0, 0, 2); tick(0, 1, 0, 0);
    enter4(1, 2, 3, 4); idle(10);
    tick(1, 0, 0, 1); tick(1, 0, 0, 2); tick(1, 1, 0, 3);
    check("clear_wins", 32'(bus.o_entry_count), 32'd0);
    enter4(1, 2, 3, 4); idle(10);

    // reprogram to 5678
    enter4(1, 2, 3, 4);
    tick(0, 0, 1, 0);
    enter4(5, 6, 7, 8);
    idle(2);
    tick(0, 1, 0, 0);
    enter4(1, 2, 3, 4); idle(5);
    enter4(5, 6, 7, 8); idle(2);
    tick(0, 0, 0, 0, 1);
    enter4(1, 2, 3, 4); idle(3);

    // aborted programming keeps code
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 9); tick(1, 0, 0, 9);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    enter4(1, 2, 3, 4);
    tick(0, 1, 0, 0);

    // reset mid-entry
    tick(1, 0, 0, 1); tick(1, 0, 0, 2); tick(1, 0, 0, 3);
    tick(0, 0, 0, 0, 1);
    idle(2);

    // random traffic biased toward the current code
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if ($urandom_range(0, 3) != 0 && m_mode == M_WAIT) dg = m_code[m_entered.size()];
      else dg = $urandom_range(0, 15);
      tick((r >= 100), (r >= 2 && r < 10), (r >= 10 && r < 22), dg, (r < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/combo_lock_fsm.md
# combo_lock_fsm

Combination-lock controller that consumes single-cycle button pulses from the button pulse conditioners and a digit value from switches. It compares a fixed-length digit sequence against a stored code and drives unlock, error and lockout indicators. While unlocked it also lets the user program a new code. It is the decision stage of the lock, directly downstream of the press-to-pulse conditioning.

## Interface
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: digits per combination (≥2).
- CODE, 16'h1234: reset code, DIGIT_W*CODE_LEN bits; digit 0 is the most-significant field.
- MAX_FAIL, 3: consecutive wrong combinations that trigger lockout (≥1).
- ERR_CYCLES, 50_000_000: cycles Error is held.
- OPEN_CYCLES, 250_000_000: cycles Unlocked is held without relock.
- LOCKOUT_CYCLES, 500_000_000: cycles Locked_out is held.
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Digit  in  DIGIT_W  digit value, sampled only in a cycle where Enter_pulse=1.
- Enter_pulse  in  1  one-cycle pulse: accept Digit.
- Clear_pulse  in  1  one-cycle pulse: abandon entry / relock / abort programming.
- Set_pulse  in  1  one-cycle pulse: enter programming mode (OPEN only).
- Unlocked  out  1  high in OPEN and PROG.
- Prog  out  1  high in PROG.
- Error  out  1  high in ERR.
- Locked_out  out  1  high in LOCKOUT.
- Entry_count  out  $clog2(CODE_LEN)  digits accepted so far in ENTRY/PROG; 0 elsewhere.

## Operation
- States: ENTRY, OPEN, ERR, LOCKOUT, PROG.
- Reset: state ENTRY; stored code = CODE; index = 0; mismatch flag = 0; fail count = 0; timer = 0. All outputs are 0.
- ENTRY, Enter_pulse:
  - Compare Digit with stored digit[index] and OR the result into the mismatch flag.
  - If index < CODE_LEN-1, increment index.
  - On the last digit, if no mismatch (including this digit): go to OPEN and clear fail count.
  - On the last digit, otherwise: increment fail count (saturating at MAX_FAIL). Go to LOCKOUT if the count reaches MAX_FAIL, else go to ERR.
  - Index and mismatch flag reset to 0 on every exit from ENTRY.
- ENTRY, Clear_pulse: index = 0 and mismatch = 0. Fail count is unchanged.
- ERR: lasts exactly ERR_CYCLES, then returns to ENTRY. All pulses are ignored.
- LOCKOUT: lasts exactly LOCKOUT_CYCLES, then returns to ENTRY with fail count = 0. All pulses are ignored.
- OPEN:
  - Clear_pulse returns to ENTRY (relock).
  - Set_pulse goes to PROG.
  - Otherwise, after OPEN_CYCLES, returns to ENTRY.
  - Enter_pulse is ignored.
- PROG:
  - Enter_pulse writes Digit into shadow[index] and increments index.
  - On the CODE_LEN-th digit, the stored code is replaced by the shadow plus that digit in one cycle. Then go to OPEN with the timer reloaded.
  - Clear_pulse aborts to OPEN with the stored code unchanged and the timer reloaded.
  - No timeout runs in PROG.
- Simultaneous pulses, priority Clear > Set > Enter. A lower-priority pulse in the same cycle is dropped.
- The stored code is volatile: Reset restores CODE.

## Timing
- Pulses are sampled at the posedge. Outputs are Moore, decoded from registered state.
- Each output changes on the same edge that samples the causing pulse, so it is visible one cycle after the pulse cycle.
- Timed states use one shared down-counter:
  - Loaded with N-1 on state entry.
  - Exits on the edge where the counter is 0.
  - The corresponding output is therefore high for exactly N cycles.
- A mid-operation Reset in any state takes effect on the next edge:
  - Partial entry, fail count and the PROG shadow are discarded.
  - The stored code reverts to CODE.
- Entry_count reflects the index after the edge. It returns to 0 on the edge that completes the final digit.

## Structure
- Package combo_lock_pkg holds the state encodings (ST_ENTRY, ST_OPEN, ST_ERR, ST_LOCKOUT, ST_PROG; 3-bit) and a width function for the timer, sized from max(ERR_CYCLES, OPEN_CYCLES, LOCKOUT_CYCLES).
- One sub-module, lock_timer:
  - Inputs: load, load value.
  - Outputs: done (counter==0).
  - Synchronous reset to 0.
- The FSM, code register, shadow register and fail counter live in combo_lock_fsm.

## Test plan
Bench parameters: CODE=16'h1234, MAX_FAIL=3, ERR_CYCLES=4, OPEN_CYCLES=8, LOCKOUT_CYCLES=16.
- Enter 1,2,3,4 → Unlocked rises one cycle after the 4th pulse, stays high 8 cycles, then ENTRY with Entry_count=0.
- Enter 1,2,9,4 → Error high exactly 4 cycles, fail count 1. Then 1,2,3,4 → Unlocked and fail count 0.
- Three wrong combinations → Locked_out high 16 cycles. Enter pulses during lockout are ignored. Afterwards 1,2,3,4 unlocks.
- Enter 1,2, then Clear, then 1,2,3,4 → unlock. Clear and Enter in the same cycle → Entry_count goes to 0 and that digit is dropped.
- While OPEN: Set, then 5,6,7,8 → Prog falls and OPEN reloads. Relock with Clear. Then 1,2,3,4 → Error; 5,6,7,8 → Unlocked. Reset → code is 1234 again.
- In PROG: enter 9,9, then Clear → OPEN with the code still 1234. Reset asserted mid-ENTRY after 3 digits → all outputs 0 next cycle.
